// File: rtl/seq_det_param_if.sv
// Serial pattern-detector bus: qualified bit stream, runtime config, match outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; in_valid qualifies each bit, the detector always accepts.
//
// Ports (master = stream/config source, slave = detector):
//   in_valid, data_in       serial bit and its qualifier
//   overlap_en              1 = overlapping detection, 0 = non-overlapping
//   cfg_load, cfg_pattern   load a new pattern (MSB oldest) and restart detection
//   data_out                registered one-cycle match pulse
//   match_cnt               saturating match count (only with MATCH_COUNT_EN)
interface seq_det_param_if #(
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               in_valid;
  logic               data_in;
  logic               overlap_en;
  logic               cfg_load;
  logic [SEQ_LEN-1:0] cfg_pattern;
  logic               data_out;
`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output in_valid, data_in, overlap_en, cfg_load, cfg_pattern,
    input  data_out, match_cnt
  );
  modport slave (
    input  in_valid, data_in, overlap_en, cfg_load, cfg_pattern,
    output data_out, match_cnt
  );
`else
  modport master (
    output in_valid, data_in, overlap_en, cfg_load, cfg_pattern,
    input  data_out
  );
  modport slave (
    input  in_valid, data_in, overlap_en, cfg_load, cfg_pattern,
    output data_out
  );
`endif
endinterface

// File: rtl/seq_det_param.sv
// Parametrised serial bit-pattern detector with runtime pattern load and overlap mode.
// Latency: data_out pulses one cycle after the final pattern bit is sampled.
// Backpressure: none; bits are taken whenever in_valid=1 and cfg_load=0.
//
// Ports: clk (rising edge), reset (async, active-high), bus (seq_det_param_if.slave).
// Optional feature: define MATCH_COUNT_EN to add the saturating match_cnt output.
module seq_det_param #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1001,
  parameter int                 CNT_W   = 8
) (
  input logic           clk,
  input logic           reset,
  seq_det_param_if.slave bus
);

  localparam int FW = $clog2(SEQ_LEN + 1);

  logic [SEQ_LEN-1:0] pattern_reg;
  logic [SEQ_LEN-1:0] hist;
  logic [SEQ_LEN-1:0] new_hist;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_inc;
  logic               match;
  logic               accept;
  logic               data_out_q;

  always_comb begin
    accept   = bus.in_valid && !bus.cfg_load;
    new_hist = {hist[SEQ_LEN-2:0], bus.data_in};
    // Fill gate: history bits that were never shifted in (reset/cleared zeros)
    // must not take part in a match, so SEQ_LEN real bits are required.
    match    = (fill >= FW'(SEQ_LEN - 1)) && (new_hist == pattern_reg);
    fill_inc = (fill == FW'(SEQ_LEN)) ? fill : fill + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_reg <= PATTERN;
      hist        <= '0;
      fill        <= '0;
      data_out_q  <= 1'b0;
    end else if (bus.cfg_load) begin
      // Config load wins over a valid bit; that bit is dropped.
      pattern_reg <= bus.cfg_pattern;
      hist        <= '0;
      fill        <= '0;
      data_out_q  <= 1'b0;
    end else if (bus.in_valid) begin
      data_out_q <= match;
      if (match && !bus.overlap_en) begin
        // Non-overlapping: matched bits are consumed, start from an empty window.
        hist <= '0;
        fill <= '0;
      end else if (match) begin
        hist <= new_hist;
        fill <= FW'(SEQ_LEN);
      end else begin
        hist <= new_hist;
        fill <= fill_inc;
      end
    end else begin
      // Gap cycle: window holds, no pulse.
      data_out_q <= 1'b0;
    end
  end

  assign bus.data_out = data_out_q;

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] match_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_cnt_q <= '0;
    end else if (bus.cfg_load) begin
      match_cnt_q <= '0;
    end else if (accept && match && (match_cnt_q != {CNT_W{1'b1}})) begin
      match_cnt_q <= match_cnt_q + 1'b1;
    end
  end

  assign bus.match_cnt = match_cnt_q;
`else
  // accept only feeds the optional counter.
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed self-checking bench for seq_det_param (pattern 1001 default, CNT_W=2).
// Latency: inputs driven 1 ns after a rising edge, outputs sampled 1 ns after the next.
// Backpressure: n/a.
module tb_seq_det_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  seq_det_param_if #(.SEQ_LEN(4), .CNT_W(2)) bus ();

  seq_det_param #(
    .SEQ_LEN(4),
    .PATTERN(4'b1001),
    .CNT_W  (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers only; every check is done inline in the test tasks.
  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.data_in     = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_pattern = 4'b0000;
  endtask

  task automatic send_bit(input logic d);
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.cfg_load = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.overlap_en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data_out: got %b need 0", bus.data_out);
    end
`ifdef MATCH_COUNT_EN
    n_checks++;
    if (bus.match_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_match_cnt: got %0d need 0", bus.match_cnt);
    end
`endif
    reset = 1'b0;
  endtask

  // Stream 1001001 in one mode; exp holds the expected pulse after each bit.
  task automatic run_1001001(input logic ov, input logic [6:0] exp, input string name);
    logic [6:0] bits;
    bits = 7'b1001001;
    do_reset();
    bus.overlap_en = ov;
    for (int i = 0; i < 7; i++) begin
      send_bit(bits[6-i]);
      n_checks++;
      if (bus.data_out !== exp[6-i]) begin
        n_fail++;
        $display("FAIL %s bit%0d: got %b need %b", name, i + 1, bus.data_out, exp[6-i]);
      end
    end
  endtask

  task automatic test_non_overlap();
    run_1001001(1'b0, 7'b0001000, "non_overlap");
  endtask

  task automatic test_overlap();
    run_1001001(1'b1, 7'b0001001, "overlap");
  endtask

  task automatic test_cfg_zero_pattern();
    logic [4:0] exp;
    exp = 5'b00011;
    do_reset();
    bus.overlap_en  = 1'b1;
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = 4'b0000;
    @(posedge clk);
    #1;
    bus.cfg_load = 1'b0;
    n_checks++;
    if (bus.data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_cfg_load: got %b need 0", bus.data_out);
    end
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0);
      n_checks++;
      if (bus.data_out !== exp[4-i]) begin
        n_fail++;
        $display("FAIL zero_pat bit%0d: got %b need %b", i + 1, bus.data_out, exp[4-i]);
      end
    end
    // A gap after a pulse clears data_out.
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_pat_gap: got %b need 0", bus.data_out);
    end
  endtask

  task automatic test_gap();
    do_reset();
    bus.overlap_en = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b0;
      bus.data_in  = 1'b1;   // ignored while in_valid=0
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.data_out !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_cycle%0d: got %b need 0", i, bus.data_out);
      end
    end
    send_bit(1'b0);
    n_checks++;
    if (bus.data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_bit3: got %b need 0", bus.data_out);
    end
    send_bit(1'b1);
    n_checks++;
    if (bus.data_out !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_final: got %b need 1", bus.data_out);
    end
  endtask

  task automatic test_cfg_midstream();
    logic [3:0] bits;
    logic [3:0] exp;
    bits = 4'b1101;
    exp  = 4'b0001;
    do_reset();
    bus.overlap_en = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    // Load with a valid 1 that would have completed 1001; it must be dropped.
    bus.in_valid    = 1'b1;
    bus.data_in     = 1'b1;
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = 4'b1101;
    @(posedge clk);
    #1;
    bus.cfg_load = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_mid_load: got %b need 0", bus.data_out);
    end
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[3-i]);
      n_checks++;
      if (bus.data_out !== exp[3-i]) begin
        n_fail++;
        $display("FAIL cfg_mid bit%0d: got %b need %b", i + 1, bus.data_out, exp[3-i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    bus.overlap_en = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    n_checks++;
    if (bus.data_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pulse: got %b need 1", bus.data_out);
    end
    // Asynchronous reset clears the pulse without waiting for an edge.
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async_clear: got %b need 0", bus.data_out);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    reset = 1'b1;
    #3;
    reset = 1'b0;
    send_bit(1'b1);
    n_checks++;
    if (bus.data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_partial: got %b need 0", bus.data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    int         pulses;
    exp    = 8'b00011111;
    pulses = 0;
    do_reset();
    bus.overlap_en  = 1'b1;
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = 4'b1111;
    @(posedge clk);
    #1;
    bus.cfg_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      if (bus.data_out === 1'b1) pulses++;
      n_checks++;
      if (bus.data_out !== exp[7-i]) begin
        n_fail++;
        $display("FAIL b2b bit%0d: got %b need %b", i + 1, bus.data_out, exp[7-i]);
      end
    end
    n_checks++;
    if (pulses != 5) begin
      n_fail++;
      $display("FAIL b2b_pulse_count: got %0d need 5", pulses);
    end
`ifdef MATCH_COUNT_EN
    n_checks++;
    if (bus.match_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL cnt_saturated: got %0d need 3", bus.match_cnt);
    end
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = 4'b1111;
    @(posedge clk);
    #1;
    bus.cfg_load = 1'b0;
    n_checks++;
    if (bus.match_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL cnt_cfg_clear: got %0d need 0", bus.match_cnt);
    end
`endif
  endtask

  initial begin
    bus.overlap_en = 1'b0;
    idle_inputs();
    test_reset();
    test_non_overlap();
    test_overlap();
    test_cfg_zero_pattern();
    test_gap();
    test_cfg_midstream();
    test_reset_midstream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
